// File: rtl/reg_operand_reader_pkg.sv
// Shared CPU register-file definitions: data/index widths and the operand
// reader state encoding.
package reg_operand_reader_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_NREGS = 8;
  localparam int RF_AW    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    DONE   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/reg_fwd_mux.sv
// Write-forward select: a write landing on the register being read this cycle
// wins over the bank's (still stale) read data.
module reg_fwd_mux #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] fwd_data
);

  logic hit;

  assign hit      = wr_en && (wr_addr == rd_addr);
  assign fwd_data = hit ? wr_data : rd_data;

endmodule

// File: rtl/reg_operand_reader.sv
// Operand-fetch sequencer: reads one or two registers through the bank's single
// read port, forwards same-cycle writes, and holds a snapshot until consumed.
module reg_operand_reader
  import reg_operand_reader_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREGS = RF_NREGS,
  parameter int AW    = RF_AW
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_ra,
  input  logic [AW-1:0]    req_rb,
  input  logic             req_two,
  output logic [AW-1:0]    rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [15:0]      rd_count
);

  if (NREGS > (1 << AW)) begin : g_bad_cfg
    $error("NREGS does not fit in AW index bits");
  end

  rd_state_e        state_q, state_d;
  logic [AW-1:0]    ra_q, rb_q;
  logic             two_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [15:0]      rd_count_q;
  logic [WIDTH-1:0] fwd_data;

  // Single forwarding path; the read address already selects ra_q or rb_q.
  reg_fwd_mux #(.WIDTH(WIDTH), .AW(AW)) u_fwd (
    .rd_addr  (rf_raddr),
    .rd_data  (rf_rdata),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .fwd_data (fwd_data)
  );

  // Outputs decode from state only; reset just masks the request side.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rf_raddr  = '0;
    op_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ_A;
      end
      READ_A: begin
        rf_raddr = ra_q;
        state_d  = two_q ? READ_B : DONE;
      end
      READ_B: begin
        rf_raddr = rb_q;
        state_d  = DONE;
      end
      DONE: begin
        op_valid = 1'b1;
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      req_ready = 1'b0;
      rf_raddr  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      ra_q       <= '0;
      rb_q       <= '0;
      two_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_count_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            ra_q  <= req_ra;
            rb_q  <= req_rb;
            two_q <= req_two;
          end
        end
        READ_A: begin
          op_a_q <= fwd_data;
          if (!two_q) op_b_q <= '0;
        end
        READ_B: op_b_q <= fwd_data;
        DONE: begin
          if (op_ready) rd_count_q <= rd_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_reg_operand_reader.sv
// Scoreboarded bench for reg_operand_reader with a behavioural register bank.
module tb_reg_operand_reader;
  import reg_operand_reader_pkg::*;

  localparam int W = 16;
  localparam int A = 3;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_two = 1'b0;
  logic         req_ready;
  logic [A-1:0] req_ra = '0, req_rb = '0;
  logic [A-1:0] rf_raddr;
  logic [W-1:0] rf_rdata;
  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         op_valid;
  logic         op_ready = 1'b0;
  logic [W-1:0] op_a, op_b;
  logic [15:0]  rd_count;

  reg_operand_reader dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra(req_ra), .req_rb(req_rb), .req_two(req_two),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .rd_count(rd_count)
  );

  always #5 CLK = ~CLK;

  // Bank model: combinational read, clocked write.
  logic [W-1:0] bank [8] = '{default: '0};
  assign rf_rdata = bank[rf_raddr];
  always @(posedge CLK) if (wr_en) bank[wr_addr] <= wr_data;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } exp_t;
  exp_t sb [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [A-1:0] addr, input logic [W-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Drive a request until accepted; leaves the DUT in READ_A.
  task automatic start(input logic [A-1:0] ra, input logic [A-1:0] rb, input logic two,
                       input logic [W-1:0] ea, input logic [W-1:0] eb, input bit push,
                       output int waited);
    exp_t e;
    e.a = ea; e.b = eb;
    if (push) sb.push_back(e);
    req_valid = 1'b1; req_ra = ra; req_rb = rb; req_two = two;
    waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("raddr_a", {29'd0, rf_raddr}, {29'd0, ra});
  endtask

  // Completion monitor: handshake happens on the next rising edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!reset && op_valid && op_ready) begin
      chk("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("op_a", {16'd0, op_a}, {16'd0, e.a});
        chk("op_b", {16'd0, op_b}, {16'd0, e.b});
      end
    end
  end

  initial begin
    int w;
    tick(); tick();
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_raddr", {29'd0, rf_raddr}, 32'd0);
    chk("rst_count", {16'd0, rd_count}, 32'd0);
    chk("rst_op_a", {16'd0, op_a}, 32'd0);
    chk("rst_op_b", {16'd0, op_b}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Single operand; a write to another register must not forward.
    wr(3'd3, 16'h1234);
    op_ready = 1'b1;
    start(3'd3, 3'd0, 1'b0, 16'h1234, 16'h0000, 1'b1, w);
    chk("lat1_early", {31'd0, op_valid}, 32'd0);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h9999;
    tick();
    wr_en = 1'b0;
    chk("lat1", {31'd0, op_valid}, 32'd1);
    tick();
    chk("count1", {16'd0, rd_count}, 32'd1);
    chk("done_to_idle", {31'd0, op_valid}, 32'd0);

    // Two operands: address sequence and latency.
    wr(3'd1, 16'h00AA);
    wr(3'd5, 16'hBEEF);
    start(3'd1, 3'd5, 1'b1, 16'h00AA, 16'hBEEF, 1'b1, w);
    chk("lat2_early_a", {31'd0, op_valid}, 32'd0);
    tick();
    chk("raddr_b", {29'd0, rf_raddr}, 32'd5);
    chk("lat2_early_b", {31'd0, op_valid}, 32'd0);
    tick();
    chk("lat2", {31'd0, op_valid}, 32'd1);
    tick();
    chk("count2", {16'd0, rd_count}, 32'd2);

    // Forward into READ_A.
    start(3'd2, 3'd0, 1'b0, 16'hCAFE, 16'h0000, 1'b1, w);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hCAFE;
    tick();
    wr_en = 1'b0;
    tick();
    chk("count3", {16'd0, rd_count}, 32'd3);

    // ra==rb: second read forwards a write landing in READ_B only.
    wr(3'd6, 16'h0001);
    start(3'd6, 3'd6, 1'b1, 16'h0001, 16'h7777, 1'b1, w);
    tick();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h7777;
    tick();
    wr_en = 1'b0;
    tick();
    chk("count4", {16'd0, rd_count}, 32'd4);

    // Snapshot held through writes while the consumer stalls.
    op_ready = 1'b0;
    start(3'd1, 3'd5, 1'b1, 16'h00AA, 16'hBEEF, 1'b1, w);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555;
      tick();
      chk("hold_valid", {31'd0, op_valid}, 32'd1);
      chk("hold_op_a", {16'd0, op_a}, 32'h00AA);
    end
    wr_en = 1'b0;
    op_ready = 1'b1;
    tick();
    chk("release_idle", {31'd0, req_ready}, 32'd1);
    chk("count5", {16'd0, rd_count}, 32'd5);
    start(3'd1, 3'd0, 1'b0, 16'h5555, 16'h0000, 1'b1, w);
    chk("accept_wait", w, 32'd0);
    tick(); tick();
    chk("count6", {16'd0, rd_count}, 32'd6);

    // Reset during READ_B discards the transaction.
    start(3'd1, 3'd5, 1'b1, 16'h0000, 16'h0000, 1'b0, w);
    tick();
    chk("mid_raddr_b", {29'd0, rf_raddr}, 32'd5);
    reset = 1'b1;
    tick();
    chk("mid_op_valid", {31'd0, op_valid}, 32'd0);
    chk("mid_op_a", {16'd0, op_a}, 32'd0);
    chk("mid_count", {16'd0, rd_count}, 32'd0);
    chk("mid_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_raddr", {29'd0, rf_raddr}, 32'd0);
    reset = 1'b0;
    #1;
    start(3'd4, 3'd0, 1'b0, 16'h9999, 16'h0000, 1'b1, w);
    tick();
    chk("post_rst_valid", {31'd0, op_valid}, 32'd1);
    tick();
    chk("post_rst_count", {16'd0, rd_count}, 32'd1);

    // Counter wrap from a preloaded value.
    force dut.rd_count_q = 16'hFFFF;
    #1;
    release dut.rd_count_q;
    chk("preload", {16'd0, rd_count}, 32'h0000FFFF);
    start(3'd3, 3'd0, 1'b0, 16'h1234, 16'h0000, 1'b1, w);
    tick(); tick();
    chk("wrap", {16'd0, rd_count}, 32'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
